// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register feeding the ALU with valid/ready handshake, MEM/WB forwarding,
// load-use hazard detection, illegal-code trapping and a saturating stall counter.
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_rs1_addr,
   input  logic [REG_AW-1:0] in_rs2_addr,
   input  logic [DATA_W-1:0] in_rs1_data,
   input  logic [DATA_W-1:0] in_rs2_data,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic [3:0]        in_alu_control,
   input  logic [REG_AW-1:0] in_rd_addr,
   input  logic              in_reg_write,
   input  logic              mem_fwd_we,
   input  logic              mem_fwd_load,
   input  logic [REG_AW-1:0] mem_fwd_rd,
   input  logic [DATA_W-1:0] mem_fwd_data,
   input  logic              wb_fwd_we,
   input  logic [REG_AW-1:0] wb_fwd_rd,
   input  logic [DATA_W-1:0] wb_fwd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] in2,
   output logic [3:0]        alu_control,
   output logic [REG_AW-1:0] out_rd_addr,
   output logic              out_reg_write,
   output logic              out_illegal,
   output logic [CNT_W-1:0]  stall_count
);
   logic [REG_AW-1:0] rs1_q, rs2_q;
   logic imm_q, load_use, cap, illegal;
   function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] d);
      return rs == '0 ? d :
             (mem_fwd_we && !mem_fwd_load && mem_fwd_rd == rs) ? mem_fwd_data :
             (wb_fwd_we && wb_fwd_rd == rs) ? wb_fwd_data : d;
   endfunction
   always_comb begin
      load_use = in_valid && mem_fwd_we && mem_fwd_load && mem_fwd_rd != '0 &&
                 (mem_fwd_rd == in_rs1_addr || (!in_use_imm && mem_fwd_rd == in_rs2_addr));
      in_ready = (!out_valid || out_ready) && !load_use && !flush;
      cap      = in_valid && in_ready;
      illegal  = in_alu_control > 4'd8;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         in1           <= '0;
         in2           <= '0;
         alu_control   <= 4'b0000;
         out_rd_addr   <= '0;
         out_reg_write <= 1'b0;
         out_illegal   <= 1'b0;
         stall_count   <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         imm_q         <= 1'b0;
      end else begin
         if (flush) out_valid <= 1'b0;
         else if (cap) begin
            out_valid     <= 1'b1;
            in1           <= fwd(in_rs1_addr, in_rs1_data);
            in2           <= in_use_imm ? in_imm : fwd(in_rs2_addr, in_rs2_data);
            alu_control   <= illegal ? 4'b0010 : in_alu_control;
            out_rd_addr   <= in_rd_addr;
            out_reg_write <= in_reg_write && !illegal;
            out_illegal   <= illegal;
            rs1_q         <= in_rs1_addr;
            rs2_q         <= in_rs2_addr;
            imm_q         <= in_use_imm;
         end else if (out_valid && out_ready) out_valid <= 1'b0;
         else if (out_valid) begin
            // held operands keep tracking producers that retire while the consumer stalls
            in1 <= fwd(rs1_q, in1);
            in2 <= imm_q ? in2 : fwd(rs2_q, in2);
         end
         if (load_use && (!out_valid || out_ready) && !(&stall_count)) stall_count <= stall_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a behavioural model, plus literal checks.
module tb_alu_issue_stage;
   logic clk = 0, rst, flush, in_valid, in_ready, in_use_imm, in_reg_write;
   logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr, mem_fwd_rd, wb_fwd_rd, out_rd_addr;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, mem_fwd_data, wb_fwd_data, in1, in2;
   logic [3:0] in_alu_control, alu_control;
   logic mem_fwd_we, mem_fwd_load, wb_fwd_we, out_valid, out_ready, out_reg_write, out_illegal;
   logic [15:0] stall_count;
   int total = 0, bad = 0;
   bit known = 0;
   bit m_v, m_we, m_ill, m_imm;
   logic [31:0] m_in1, m_in2;
   logic [3:0] m_alu;
   logic [4:0] m_rd, m_rs1, m_rs2;
   int m_cnt;

   alu_issue_stage dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rs1_data(in_rs1_data),
      .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_alu_control(in_alu_control), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
      .mem_fwd_we(mem_fwd_we), .mem_fwd_load(mem_fwd_load), .mem_fwd_rd(mem_fwd_rd),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
      .wb_fwd_data(wb_fwd_data), .out_valid(out_valid), .out_ready(out_ready), .in1(in1), .in2(in2),
      .alu_control(alu_control), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
      .out_illegal(out_illegal), .stall_count(stall_count));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] d);
      if (rs == 0) return d;
      if (mem_fwd_we && !mem_fwd_load && mem_fwd_rd == rs) return mem_fwd_data;
      if (wb_fwd_we && wb_fwd_rd == rs) return wb_fwd_data;
      return d;
   endfunction

   // model: compares registered outputs and in_ready, then advances on the inputs seen this cycle
   always begin
      bit lu, rdy;
      @(negedge clk);
      #2;
      lu  = in_valid && mem_fwd_we && mem_fwd_load && mem_fwd_rd != 0 &&
            (mem_fwd_rd == in_rs1_addr || (!in_use_imm && mem_fwd_rd == in_rs2_addr));
      rdy = (!m_v || out_ready) && !lu && !flush;
      if (known) begin
         chk("out_valid", out_valid, m_v);
         chk("in1", in1, m_in1);
         chk("in2", in2, m_in2);
         chk("alu_control", alu_control, m_alu);
         chk("out_rd_addr", out_rd_addr, m_rd);
         chk("out_reg_write", out_reg_write, m_we);
         chk("out_illegal", out_illegal, m_ill);
         chk("stall_count", stall_count, m_cnt);
         chk("in_ready", in_ready, rdy);
      end
      if (rst) begin
         {m_v, m_we, m_ill, m_imm} = 0;
         m_in1 = 0; m_in2 = 0; m_alu = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
         known = 1;
      end else begin
         if (lu && (!m_v || out_ready) && m_cnt < 65535) m_cnt++;
         if (flush) m_v = 0;
         else if (in_valid && rdy) begin
            m_v = 1;
            m_in1 = pick(in_rs1_addr, in_rs1_data);
            m_in2 = in_use_imm ? in_imm : pick(in_rs2_addr, in_rs2_data);
            m_ill = !(in_alu_control inside {[0:8]});
            m_alu = m_ill ? 4'd2 : in_alu_control;
            m_we  = in_reg_write && !m_ill;
            m_rd  = in_rd_addr; m_rs1 = in_rs1_addr; m_rs2 = in_rs2_addr; m_imm = in_use_imm;
         end else if (m_v && out_ready) m_v = 0;
         else if (m_v) begin
            m_in1 = pick(m_rs1, m_in1);
            if (!m_imm) m_in2 = pick(m_rs2, m_in2);
         end
      end
   end

   task automatic clr();
      {rst, flush, in_valid, in_use_imm, in_reg_write, mem_fwd_we, mem_fwd_load, wb_fwd_we} = 0;
      out_ready = 1;
      in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; mem_fwd_rd = 0; wb_fwd_rd = 0;
      in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; mem_fwd_data = 0; wb_fwd_data = 0;
      in_alu_control = 0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      clr();
      rst = 1;
      tick(); tick();
      rst = 0;
      #3;
      chk("rst out_valid", out_valid, 0); chk("rst in1", in1, 0); chk("rst in2", in2, 0);
      chk("rst alu", alu_control, 0); chk("rst stall", stall_count, 0); chk("rst in_ready", in_ready, 1);
      tick();
      in_valid = 1; in_rs1_addr = 1; in_rs2_addr = 2; in_rs1_data = 5; in_rs2_data = 7;
      in_alu_control = 4'b0010; in_rd_addr = 3; in_reg_write = 1;
      tick(); clr(); #3;
      chk("t1 valid", out_valid, 1); chk("t1 in1", in1, 5); chk("t1 in2", in2, 7); chk("t1 alu", alu_control, 2);
      tick();
      in_valid = 1; in_rs1_addr = 3; in_rs1_data = 1; in_alu_control = 4'b0100;
      mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h10; wb_fwd_we = 1; wb_fwd_rd = 3; wb_fwd_data = 32'h20;
      tick(); clr(); #3;
      chk("t2 mem beats wb", in1, 32'h10);
      tick();
      in_valid = 1; mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 32'hFF;
      tick(); clr(); #3;
      chk("t2 x0 no fwd", in1, 0);
      tick();
      in_valid = 1; in_rs1_addr = 1; in_rs2_addr = 4; mem_fwd_we = 1; mem_fwd_load = 1; mem_fwd_rd = 4;
      #3 chk("t3 stall ready", in_ready, 0);
      tick();
      mem_fwd_we = 0; mem_fwd_load = 0;
      #3 chk("t3 ready again", in_ready, 1); chk("t3 stall_count", stall_count, 1);
      tick(); clr();
      tick();
      in_valid = 1; in_rs1_addr = 1; in_rs2_addr = 4; in_use_imm = 1; in_imm = 3;
      mem_fwd_we = 1; mem_fwd_load = 1; mem_fwd_rd = 4;
      #3 chk("t3 imm no stall", in_ready, 1);
      tick(); clr(); #3;
      chk("t3 in2 imm", in2, 3); chk("t3 count kept", stall_count, 1);
      tick();
      in_valid = 1; in_rs1_addr = 5; out_ready = 0;
      tick(); clr(); out_ready = 0; #3;
      chk("t4 held", out_valid, 1); chk("t4 in1 0", in1, 0);
      tick();
      in_valid = 1; out_ready = 0; wb_fwd_we = 1; wb_fwd_rd = 5; wb_fwd_data = 32'hAB;
      #3 chk("t4 ready low", in_ready, 0);
      tick(); #3;
      chk("t4 tracked", in1, 32'hAB); chk("t4 ready low2", in_ready, 0);
      tick(); clr(); #3;
      chk("t4 still held", out_valid, 1);
      tick(); #3;
      chk("t4 drained", out_valid, 0); chk("t4 data holds", in1, 32'hAB);
      tick();
      in_valid = 1; in_alu_control = 4'b1111; in_reg_write = 1; in_rd_addr = 7;
      tick(); clr(); #3;
      chk("t5 illegal", out_illegal, 1); chk("t5 alu", alu_control, 2); chk("t5 we", out_reg_write, 0);
      chk("t5 issued", out_valid, 1);
      tick();
      flush = 1; in_valid = 1; in_rd_addr = 9;
      #3 chk("t5 flush ready", in_ready, 0);
      tick(); clr(); #3;
      chk("t5 flushed", out_valid, 0); chk("t5 dropped", out_rd_addr, 7);
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 15) == 0);
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         in_use_imm = $urandom_range(0, 3) == 0;
         in_reg_write = $urandom;
         in_rs1_addr = $urandom_range(0, 7); in_rs2_addr = $urandom_range(0, 7);
         in_rd_addr = $urandom; in_alu_control = $urandom;
         in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
         mem_fwd_we = $urandom; mem_fwd_load = $urandom_range(0, 3) == 0; mem_fwd_rd = $urandom_range(0, 7);
         mem_fwd_data = $urandom;
         wb_fwd_we = $urandom; wb_fwd_rd = $urandom_range(0, 7); wb_fwd_data = $urandom;
      end
      tick(); clr(); rst = 1;
      tick(); clr();
      in_valid = 1; in_rs1_addr = 1; mem_fwd_we = 1; mem_fwd_load = 1; mem_fwd_rd = 1;
      repeat (65540) tick();
      #3 chk("t6 saturated", stall_count, 16'hFFFF);
      tick(); clr(); in_valid = 1; in_rs1_addr = 2; out_ready = 0;
      tick(); clr(); out_ready = 0; #3;
      chk("t6 holding", out_valid, 1);
      tick(); rst = 1; out_ready = 0;
      tick(); clr(); #3;
      chk("t6 rst mid-hold", out_valid, 0); chk("t6 rst count", stall_count, 0);
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
